// File: rtl/alt_vipitc131_common_pkg.sv
// Shared definitions for the common burst-read scheduler.
// Holds the scheduler state encoding plus the elaboration-time helpers for
// ceiling-log2 sizing and bytes-per-word derivation.
package alt_vipitc131_common_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = 32'(i) + 32'd1;
            end
        end
        return result;
    endfunction

    // Bytes per word for a given data width.
    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/alt_vipitc131_common_burst_splitter.sv
// Line/burst address and length generator.
// load    : latch frame geometry and present the first command.
// advance : current command was accepted; present the next one.
// addr/len/last are registered so they can be driven straight onto the
// master command bus; len_nxt_c is the value len takes on the next edge,
// used by the scheduler's credit check.
module alt_vipitc131_common_burst_splitter
    import alt_vipitc131_common_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 11,
    parameter int unsigned DIM_WIDTH  = 16,
    parameter int unsigned MAX_BURST  = 32,
    parameter int unsigned BPW        = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] line_stride,
    input  logic [DIM_WIDTH-1:0]  words_per_line,
    input  logic [DIM_WIDTH-1:0]  num_lines,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LEN_WIDTH-1:0]  len,
    output logic                  last,
    output logic [LEN_WIDTH-1:0]  len_nxt_c
);

    localparam int unsigned BPW_SHIFT = clog2(BPW);

    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] line_start_q, line_start_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DIM_WIDTH-1:0]  wpl_q, wpl_d;
    logic [DIM_WIDTH-1:0]  lines_q, lines_d;
    logic [DIM_WIDTH-1:0]  left_q, left_d;
    logic [DIM_WIDTH-1:0]  line_q, line_d;
    logic [DIM_WIDTH-1:0]  rem;
    logic                  last_d;

    function automatic logic [LEN_WIDTH-1:0] burst_len(input logic [DIM_WIDTH-1:0] words);
        return (32'(words) > MAX_BURST) ? LEN_WIDTH'(MAX_BURST) : LEN_WIDTH'(words);
    endfunction

    // Next-command generation; left_q counts words still to issue in the line
    // including the command currently presented.
    always_comb begin
        stride_d     = stride_q;
        line_start_d = line_start_q;
        addr_d       = addr;
        wpl_d        = wpl_q;
        lines_d      = lines_q;
        left_d       = left_q;
        line_d       = line_q;
        last_d       = last;
        rem          = left_q - DIM_WIDTH'(len);

        if (load) begin
            stride_d     = line_stride;
            wpl_d        = words_per_line;
            lines_d      = num_lines;
            line_start_d = base_addr;
            addr_d       = base_addr;
            left_d       = words_per_line;
            line_d       = '0;
            last_d       = (num_lines == DIM_WIDTH'(1)) && (32'(words_per_line) <= MAX_BURST);
        end else if (advance) begin
            if (rem != '0) begin
                addr_d = addr + (ADDR_WIDTH'(len) << BPW_SHIFT);
                left_d = rem;
                last_d = ((line_q + DIM_WIDTH'(1)) == lines_q) && (32'(rem) <= MAX_BURST);
            end else begin
                // Line finished: wrap to the next line start (modulo address space).
                line_start_d = line_start_q + stride_q;
                addr_d       = line_start_q + stride_q;
                left_d       = wpl_q;
                line_d       = line_q + DIM_WIDTH'(1);
                last_d       = ((line_q + DIM_WIDTH'(2)) == lines_q) && (32'(wpl_q) <= MAX_BURST);
            end
        end

        len_nxt_c = burst_len(left_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stride_q     <= '0;
            line_start_q <= '0;
            addr         <= '0;
            wpl_q        <= '0;
            lines_q      <= '0;
            left_q       <= '0;
            line_q       <= '0;
            len          <= '0;
            last         <= 1'b0;
        end else begin
            stride_q     <= stride_d;
            line_start_q <= line_start_d;
            addr         <= addr_d;
            wpl_q        <= wpl_d;
            lines_q      <= lines_d;
            left_q       <= left_d;
            line_q       <= line_d;
            len          <= len_nxt_c;
            last         <= last_d;
        end
    end

endmodule

// File: rtl/alt_vipitc131_common_burst_read_scheduler.sv
// Frame read scheduler for the common Avalon-MM bursting master.
// Splits a lines x words frame into bursts of at most MAX_BURST words,
// credit-limits issued words against the master read FIFO depth, forwards
// consumer pops, and pulses done when every requested word is consumed.
// Ports: clock/reset (sync, active-high); start + frame geometry inputs;
// busy/done status; mm_* master command/read interface; cons_* consumer side
// (cons_data and cons_accept are combinational pass-throughs).
module alt_vipitc131_common_burst_read_scheduler
    import alt_vipitc131_common_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 11,
    parameter int unsigned MAX_BURST       = 32,
    parameter int unsigned READ_FIFO_DEPTH = 64,
    parameter int unsigned DIM_WIDTH       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] line_stride,
    input  logic [DIM_WIDTH-1:0]  words_per_line,
    input  logic [DIM_WIDTH-1:0]  num_lines,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mm_addr,
    output logic                  mm_command,
    output logic                  mm_is_burst,
    output logic                  mm_is_write_not_read,
    output logic [LEN_WIDTH-1:0]  mm_burst_length,
    output logic                  mm_read,
    input  logic [DATA_WIDTH-1:0] mm_readdata,
    input  logic                  mm_stall,
    input  logic                  cons_read,
    output logic [DATA_WIDTH-1:0] cons_data,
    output logic                  cons_accept
);

    localparam int unsigned BPW          = bytes_per_word(DATA_WIDTH);
    localparam int unsigned OUT_WIDTH    = clog2(READ_FIFO_DEPTH + 1);
    localparam int unsigned TOT_WIDTH    = 2 * DIM_WIDTH;
    localparam int unsigned CREDIT_WIDTH = ((OUT_WIDTH > LEN_WIDTH) ? OUT_WIDTH : LEN_WIDTH) + 1;

    sched_state_t          state_q, state_d;
    logic                  busy_d, done_d, command_d;
    logic [OUT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic [TOT_WIDTH-1:0]  consumed_q, consumed_d;
    logic [TOT_WIDTH-1:0]  total_q, total_d;
    logic                  accept, pop, load, split_last, credit_ok;
    logic [LEN_WIDTH-1:0]  len_nxt;

    assign mm_is_burst          = 1'b1;
    assign mm_is_write_not_read = 1'b0;
    assign mm_read              = cons_read & busy & (consumed_q < total_q);
    assign cons_data            = mm_readdata;
    assign cons_accept          = mm_read & ~mm_stall;
    assign accept               = mm_command & ~mm_stall;
    assign pop                  = cons_accept;

    alt_vipitc131_common_burst_splitter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .DIM_WIDTH  (DIM_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .BPW        (BPW)
    ) u_splitter (
        .clock          (clock),
        .reset          (reset),
        .load           (load),
        .advance        (accept),
        .base_addr      (base_addr),
        .line_stride    (line_stride),
        .words_per_line (words_per_line),
        .num_lines      (num_lines),
        .addr           (mm_addr),
        .len            (mm_burst_length),
        .last           (split_last),
        .len_nxt_c      (len_nxt)
    );

    // Credit check looks one edge ahead: next outstanding plus next length.
    // While stalled neither term moves, so a presented command stays up.
    always_comb begin
        outstanding_d = outstanding_q
                      + (accept ? OUT_WIDTH'(mm_burst_length) : OUT_WIDTH'(0))
                      - (pop ? OUT_WIDTH'(1) : OUT_WIDTH'(0));
        credit_ok     = (CREDIT_WIDTH'(outstanding_d) + CREDIT_WIDTH'(len_nxt))
                        <= CREDIT_WIDTH'(READ_FIFO_DEPTH);
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        consumed_d = consumed_q + TOT_WIDTH'(pop);
        total_d    = total_q;
        load       = 1'b0;
        command_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ISSUE;
                    load       = 1'b1;
                    total_d    = TOT_WIDTH'(words_per_line) * TOT_WIDTH'(num_lines);
                    consumed_d = '0;
                    command_d  = credit_ok;
                end
            end
            ISSUE: begin
                if (accept && split_last) begin
                    state_d = DRAIN;
                end else begin
                    command_d = credit_ok;
                end
            end
            DRAIN: begin
                if (consumed_d == total_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mm_command    <= 1'b0;
            outstanding_q <= '0;
            consumed_q    <= '0;
            total_q       <= '0;
        end else begin
            state_q       <= state_d;
            busy          <= busy_d;
            done          <= done_d;
            mm_command    <= command_d;
            outstanding_q <= outstanding_d;
            consumed_q    <= consumed_d;
            total_q       <= total_d;
        end
    end

endmodule

// File: tb/tb_alt_vipitc131_common_burst_read_scheduler.sv
// Directed bench for the burst read scheduler with a simple master model:
// accepted commands push word addresses as read data into a FIFO queue.
module tb_alt_vipitc131_common_burst_read_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] line_stride = '0;
    logic [15:0] words_per_line = '0;
    logic [15:0] num_lines = '0;
    logic        busy, done;
    logic [31:0] mm_addr;
    logic        mm_command, mm_is_burst, mm_is_write_not_read;
    logic [10:0] mm_burst_length;
    logic        mm_read;
    logic [31:0] rd_head = '0;
    logic        mm_stall = 1'b0;
    logic        cons_read;
    logic [31:0] cons_data;
    logic        cons_accept;

    logic        want_read = 1'b0;
    logic        force_read = 1'b0;
    int          fifo_cnt = 0;

    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] fifo[$];
    logic [31:0] cmd_addr_log[$];
    logic [10:0] cmd_len_log[$];
    int          pops = 0;
    int          done_cnt = 0;
    int          data_errs = 0;

    logic [31:0] f_base = '0;
    logic [31:0] f_stride = '0;
    int          f_wpl = 1;
    int          pop_base = 0;
    int          cmd_base = 0;
    int          done_base = 0;
    int          mon_idx;
    logic [31:0] mon_exp;

    assign cons_read = want_read & ((fifo_cnt != 0) | force_read);

    alt_vipitc131_common_burst_read_scheduler #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .LEN_WIDTH       (11),
        .MAX_BURST       (32),
        .READ_FIFO_DEPTH (64),
        .DIM_WIDTH       (16)
    ) dut (
        .clock                (clk),
        .reset                (reset),
        .start                (start),
        .base_addr            (base_addr),
        .line_stride          (line_stride),
        .words_per_line       (words_per_line),
        .num_lines            (num_lines),
        .busy                 (busy),
        .done                 (done),
        .mm_addr              (mm_addr),
        .mm_command           (mm_command),
        .mm_is_burst          (mm_is_burst),
        .mm_is_write_not_read (mm_is_write_not_read),
        .mm_burst_length      (mm_burst_length),
        .mm_read              (mm_read),
        .mm_readdata          (rd_head),
        .mm_stall             (mm_stall),
        .cons_read            (cons_read),
        .cons_data            (cons_data),
        .cons_accept          (cons_accept)
    );

    always #5 clk = ~clk;

    // Master model and transfer monitor.
    always @(posedge clk) begin
        if (reset) begin
            fifo.delete();
        end else begin
            if (mm_read && !mm_stall) begin
                mon_idx = pops - pop_base;
                mon_exp = f_base + 32'(mon_idx / f_wpl) * f_stride + 32'(mon_idx % f_wpl) * 32'd4;
                if (cons_data !== mon_exp) data_errs++;
                if (fifo.size() > 0) void'(fifo.pop_front());
                pops++;
            end
            if (mm_command && !mm_stall) begin
                cmd_addr_log.push_back(mm_addr);
                cmd_len_log.push_back(mm_burst_length);
                for (int i = 0; i < int'(mm_burst_length); i++) begin
                    fifo.push_back(mm_addr + 32'(i * 4));
                end
            end
            if (done) done_cnt++;
        end
    end

    // Read-side view of the master FIFO, updated well clear of both edges.
    always @(posedge clk) begin
        #2;
        fifo_cnt = fifo.size();
        rd_head  = (fifo.size() > 0) ? fifo[0] : 32'd0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic [31:0] a, input logic [10:0] l);
        int k;
        logic [31:0] oa;
        logic [10:0] ol;
        k  = cmd_base + idx;
        oa = 'x;
        ol = 'x;
        if (k < cmd_addr_log.size()) begin
            oa = cmd_addr_log[k];
            ol = cmd_len_log[k];
        end
        check({tag, "_addr"}, 64'(oa), 64'(a));
        check({tag, "_len"}, 64'(ol), 64'(l));
    endtask

    task automatic check_basic(input string tag);
        logic [31:0] ea[6];
        logic [10:0] el[6];
        ea = '{32'h1000, 32'h1080, 32'h1100, 32'h1400, 32'h1480, 32'h1500};
        el = '{11'd32, 11'd32, 11'd6, 11'd32, 11'd32, 11'd6};
        check({tag, "_ncmd"}, 64'(cmd_addr_log.size() - cmd_base), 64'(6));
        for (int i = 0; i < 6; i++) begin
            check_cmd($sformatf("%s_c%0d", tag, i), i, ea[i], el[i]);
        end
        check({tag, "_pops"}, 64'(pops - pop_base), 64'(140));
        check({tag, "_data"}, 64'(data_errs), 64'(0));
    endtask

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic start_frame(input logic [31:0] b, input logic [31:0] s, input int wpl, input int lines);
        f_base         = b;
        f_stride       = s;
        f_wpl          = wpl;
        pop_base       = pops;
        cmd_base       = cmd_addr_log.size();
        done_base      = done_cnt;
        base_addr      = b;
        line_stride    = s;
        words_per_line = 16'(wpl);
        num_lines      = 16'(lines);
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        int snap_pops, snap_cmds, snap_done;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_cmd", 64'(mm_command), 64'(0));
        check("rst_addr", 64'(mm_addr), 64'(0));
        check("rst_len", 64'(mm_burst_length), 64'(0));
        check("rst_read", 64'(mm_read), 64'(0));
        check("rst_is_burst", 64'(mm_is_burst), 64'(1));
        check("rst_is_wnr", 64'(mm_is_write_not_read), 64'(0));
        check("rst_accept", 64'(cons_accept), 64'(0));

        // Basic frame, with a start pulse while busy that must be ignored
        want_read = 1'b1;
        start_frame(32'h1000, 32'h400, 70, 2);
        check("basic_first_cmd", 64'(mm_command), 64'(1));
        check("basic_first_busy", 64'(busy), 64'(1));
        check("basic_first_addr", 64'(mm_addr), 64'h1000);
        check("basic_first_len", 64'(mm_burst_length), 64'(32));
        repeat (3) @(negedge clk);
        base_addr      = 32'h9000;
        words_per_line = 16'd5;
        num_lines      = 16'd1;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
        wait_done("basic", 400);
        check("basic_pops_at_done", 64'(pops - pop_base), 64'(140));
        repeat (3) @(negedge clk);
        check_basic("basic");
        check("basic_one_done", 64'(done_cnt - done_base), 64'(1));

        // Excess consumer pops after completion are not forwarded
        force_read = 1'b1;
        @(negedge clk);
        check("excess_read", 64'(mm_read), 64'(0));
        check("excess_accept", 64'(cons_accept), 64'(0));
        force_read = 1'b0;

        // Credit limit
        want_read = 1'b0;
        start_frame(32'h2000, 32'h800, 128, 1);
        repeat (8) @(negedge clk);
        check("credit_two_cmds", 64'(cmd_addr_log.size() - cmd_base), 64'(2));
        check("credit_cmd_held", 64'(mm_command), 64'(0));
        check("credit_busy", 64'(busy), 64'(1));
        want_read = 1'b1;
        repeat (31) @(negedge clk);
        check("credit_31_pops", 64'(pops - pop_base), 64'(31));
        check("credit_31_cmd", 64'(mm_command), 64'(0));
        @(negedge clk);
        check("credit_32_pops", 64'(pops - pop_base), 64'(32));
        check("credit_32_cmd", 64'(mm_command), 64'(1));
        check("credit_32_addr", 64'(mm_addr), 64'h2100);
        check("credit_32_ncmd", 64'(cmd_addr_log.size() - cmd_base), 64'(2));
        wait_done("credit", 400);
        repeat (2) @(negedge clk);
        check("credit_ncmd", 64'(cmd_addr_log.size() - cmd_base), 64'(4));
        check_cmd("credit_c3", 3, 32'h2180, 11'd32);
        check("credit_pops", 64'(pops - pop_base), 64'(128));
        check("credit_data", 64'(data_errs), 64'(0));

        // Stall mid-command
        start_frame(32'h3000, 32'h400, 70, 1);
        @(negedge clk);
        check("stall_pre_addr", 64'(mm_addr), 64'h3080);
        check("stall_pre_cmd", 64'(mm_command), 64'(1));
        mm_stall  = 1'b1;
        snap_pops = pops;
        snap_cmds = cmd_addr_log.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_addr%0d", i), 64'(mm_addr), 64'h3080);
            check($sformatf("stall_len%0d", i), 64'(mm_burst_length), 64'(32));
            check($sformatf("stall_cmd%0d", i), 64'(mm_command), 64'(1));
            check($sformatf("stall_accept%0d", i), 64'(cons_accept), 64'(0));
        end
        mm_stall = 1'b0;
        check("stall_no_pops", 64'(pops - snap_pops), 64'(0));
        check("stall_no_cmds", 64'(cmd_addr_log.size() - snap_cmds), 64'(0));
        wait_done("stall", 400);
        check("stall_pops", 64'(pops - pop_base), 64'(70));
        repeat (2) @(negedge clk);
        check("stall_ncmd", 64'(cmd_addr_log.size() - cmd_base), 64'(3));
        check_cmd("stall_c2", 2, 32'h3100, 11'd6);
        check("stall_data", 64'(data_errs), 64'(0));

        // Single-word frame
        start_frame(32'h4000, 32'h400, 1, 1);
        check("single_cmd", 64'(mm_command), 64'(1));
        check("single_addr", 64'(mm_addr), 64'h4000);
        check("single_len", 64'(mm_burst_length), 64'(1));
        @(negedge clk);
        check("single_read", 64'(mm_read), 64'(1));
        check("single_no_done_yet", 64'(done), 64'(0));
        check("single_no_second_cmd", 64'(mm_command), 64'(0));
        @(negedge clk);
        check("single_done", 64'(done), 64'(1));
        check("single_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("single_done_pulse", 64'(done), 64'(0));
        check("single_ncmd", 64'(cmd_addr_log.size() - cmd_base), 64'(1));

        // Reset mid-frame, then rerun the basic frame
        start_frame(32'h1000, 32'h400, 70, 2);
        n = 0;
        while ((cmd_addr_log.size() - cmd_base) < 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_three_cmds", 64'(cmd_addr_log.size() - cmd_base), 64'(3));
        snap_done = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_cmd", 64'(mm_command), 64'(0));
        check("midrst_addr", 64'(mm_addr), 64'(0));
        check("midrst_len", 64'(mm_burst_length), 64'(0));
        check("midrst_read", 64'(mm_read), 64'(0));
        check("midrst_state", 64'(dut.state_q), 64'(0));
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - snap_done), 64'(0));
        check("midrst_idle_cmd", 64'(mm_command), 64'(0));
        start_frame(32'h1000, 32'h400, 70, 2);
        check("rerun_first_addr", 64'(mm_addr), 64'h1000);
        wait_done("rerun", 400);
        repeat (3) @(negedge clk);
        check_basic("rerun");
        check("rerun_one_done", 64'(done_cnt - done_base), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alt_vipitc131_common_burst_read_scheduler.md
Name: alt_vipitc131_common_burst_read_scheduler

Overview:
- Sequences frame reads through the common Avalon-MM bursting master's user interface.
- Splits a rectangular frame (lines × words, base address, line stride) into read bursts of at most MAX_BURST words and issues them as master commands.
- Credit-limits issued words against the master's read-data FIFO depth so readback never overflows.
- Forwards consumer read pops to the master and asserts done once every requested word has been consumed.

Parameters:
- ADDR_WIDTH, 32, byte-address width, matches the master.
- DATA_WIDTH, 32, word width; bytes per word BPW = DATA_WIDTH/8, power of two.
- LEN_WIDTH, 11, width of burst_length on the master.
- MAX_BURST, 32, maximum words per command; 1 ≤ MAX_BURST < 2^LEN_WIDTH.
- READ_FIFO_DEPTH, 64, master read FIFO depth in words; must be ≥ MAX_BURST.
- DIM_WIDTH, 16, width of the words_per_line and num_lines fields.

Ports:
- clock  in  1  Block clock, shared with the master.
- reset  in  1  Synchronous, active-high.
- start  in  1  One-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  Frame start byte address, BPW-aligned.
- line_stride  in  ADDR_WIDTH  Bytes between successive line starts.
- words_per_line  in  DIM_WIDTH  Words per line, ≥ 1.
- num_lines  in  DIM_WIDTH  Lines per frame, ≥ 1.
- busy  out  1  High from the cycle after start until done.
- done  out  1  One-cycle pulse when the last word is consumed.
- mm_addr  out  ADDR_WIDTH  Command address.
- mm_command  out  1  Command valid.
- mm_is_burst  out  1  Tied 1.
- mm_is_write_not_read  out  1  Tied 0.
- mm_burst_length  out  LEN_WIDTH  Command length in words.
- mm_read  out  1  Read pop to the master.
- mm_readdata  in  DATA_WIDTH  Master read data.
- mm_stall  in  1  Master stall; all transfers are held while high.
- cons_read  in  1  Consumer pop request.
- cons_data  out  DATA_WIDTH  Equals mm_readdata, combinational.
- cons_accept  out  1  Equals mm_read & ~mm_stall.

Behaviour:
- Reset values: all outputs 0 except the tied mm_is_burst=1; all counters 0; state IDLE.
- Command accept: a command is taken on a cycle with mm_command & ~mm_stall.
- Command hold: while stalled, mm_command, mm_addr and mm_burst_length stay stable.
- Word pop: a word is popped on a cycle with mm_read & ~mm_stall.
- mm_read = cons_read & busy & (consumed < total). Pops after the frame completes are ignored.
- Latched frame values: start in IDLE latches the inputs and sets total = words_per_line*num_lines.
- total width is 2*DIM_WIDTH, unsigned, with no overflow.
- State IDLE → ISSUE on start.
- State ISSUE:
  - len = min(MAX_BURST, words left in current line).
  - mm_command = 1 when outstanding + len ≤ READ_FIFO_DEPTH.
  - outstanding = words issued − words popped.
- On accept:
  - line_addr advances by len*BPW.
  - words left decrements by len.
  - At line end, line_start advances by line_stride, words left reloads, and the line counter increments.
  - After the last command of the last line, ISSUE → DRAIN.
  - Next-command values are registered, so back-to-back commands are legal with no bubble.
- State DRAIN → DONE when consumed == total, which includes a pop in the current cycle.
- State DONE: done=1 for one cycle, busy=0, → IDLE.
- A single-word frame issues one command with length 1.
- Simultaneous accept and pop in one cycle: outstanding changes by +len−1.
- Outstanding never exceeds READ_FIFO_DEPTH; counter width is clog2(READ_FIFO_DEPTH+1).
- Address wrap-around is modulo 2^ADDR_WIDTH with no error.
- start while busy is ignored.
- Reset mid-frame returns to IDLE immediately with no done pulse.
  - The master FIFO contents are the system's responsibility, reset alongside.
- Latency: first mm_command is asserted 1 cycle after start.
- Handshake rules: mm_stall blocks command and pop alike; the credit check uses registered outstanding plus the current pop.

Decomposition:
- Shared package alt_vipitc131_common_pkg holds:
  - state encoding: IDLE, ISSUE, DRAIN, DONE;
  - a clog2 function;
  - BPW derivation.
- One natural sub-module: alt_vipitc131_common_burst_splitter, containing the line/burst address and length generator with advance and reload on accept.

Test Plan:
- Basic frame: base=0x1000, stride=0x400, wpl=70, lines=2, MAX_BURST=32, no stall, consumer always reading.
  - Required commands, in order: (0x1000,32), (0x1080,32), (0x1100,6), (0x1400,32), (0x1480,32), (0x1500,6).
  - Required completion: done after 140 pops, busy falls in the same cycle.
- Credit limit: DEPTH=64, consumer idle, wpl=128, lines=1.
  - Required: exactly 2 commands issued, then mm_command held 0.
  - Required: after 32 pops the third command issues.
- Stall: assert mm_stall for 5 cycles mid-command.
  - Required: mm_addr and mm_burst_length stable throughout, and no pop counted.
- Single word: wpl=1, lines=1 → one command of length 1; done 1 cycle after the pop.
- Reset mid-frame: after 3 commands, pulse reset.
  - Required: all outputs 0, state IDLE, no done pulse.
  - Required: a new start then behaves exactly as in the basic-frame case.
- start while busy: no change to the command sequence; excess cons_read after completion gives mm_read=0.
